noc_input_fifo: RTL and testbench

- Per-port input buffer of the simple_mesh_xy switch: one instance per router port.
- Write side is driven by the upstream router's output write enable (wr_en/full).
- Read side is consumed by the switch control unit (empty/rd_en); read data is registered.
- Provides occupancy, almost-full and sticky error flags for debug and backpressure.

---
 rtl/noc_input_fifo_pkg.sv | 20 ++
 rtl/noc_fifo_mem.sv | 34 +++
 rtl/noc_input_fifo.sv | 78 +++++++
 tb/tb_noc_input_fifo.sv | 134 +++++++++++++
 4 files changed

// File: rtl/noc_input_fifo_pkg.sv
// Shared constants for the simple_mesh_xy switch: default flit width and port indices
// used by the input FIFOs, control unit and output mux.
package noc_input_fifo_pkg;

  localparam int NOC_DATA_WIDTH = 8;
  localparam int NOC_NUM_PORTS  = 5;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } noc_port_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// Register array for the input FIFO: one write port and one synchronous read port.
// The read register resets to zero so data_o never carries X before the first read.
module noc_fifo_mem
  import noc_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/noc_input_fifo.sv
// Per-port input buffer of the mesh switch: wrap-bit pointers, registered read data,
// occupancy / almost-full flags and sticky overflow / underflow error flags.
module noc_input_fifo
  import noc_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    full_o,
  output logic                    almost_full_o,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          wr_acc, rd_acc;

  // Flags derive only from registered pointers, so they are glitch-free w.r.t. inputs.
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign empty_o       = (wr_ptr_q == rd_ptr_q);
  assign full_o        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign almost_full_o = (count_o >= AF_CNT);

  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // A fresh error in the clearing cycle wins over the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (wr_en_i & full_o)  | (overflow_o  & ~clr_err_i);
      underflow_o <= (rd_en_i & empty_o) | (underflow_o & ~clr_err_i);
    end
  end

  noc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_noc_input_fifo.sv
// Randomized and directed bench for noc_input_fifo against a queue-based reference model.
module tb_noc_input_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_en_i, rd_en_i, clr_err_i;
  logic [DW-1:0] data_i;
  logic          full_o, almost_full_o, empty_o, overflow_o, underflow_o;
  logic [DW-1:0] data_o;
  logic [2:0]    count_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_ovf, m_unf;

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .data_i        (data_i),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .rd_en_i       (rd_en_i),
    .data_o        (data_o),
    .empty_o       (empty_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .clr_err_i     (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count_o),       32'(q.size()));
    chk({tag, ".empty"}, 32'(empty_o),       32'(q.size() == 0));
    chk({tag, ".full"},  32'(full_o),        32'(q.size() == DEPTH));
    chk({tag, ".af"},    32'(almost_full_o), 32'(q.size() >= AF));
    chk({tag, ".data"},  32'(data_o),        32'(m_data));
    chk({tag, ".ovf"},   32'(overflow_o),    32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow_o),   32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle, update the model at the edge, check at the following negedge.
  task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] d,
                       input logic rd, input logic clr);
    bit was_full, was_empty;
    wr_en_i   = wr;
    data_i    = d;
    rd_en_i   = rd;
    clr_err_i = clr;
    @(posedge clk_i);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_ovf = (wr && was_full)  || (m_ovf && !clr);
    m_unf = (rd && was_empty) || (m_unf && !clr);
    if (rd && !was_empty) m_data = q.pop_front();
    if (wr && !was_full)  q.push_back(d);
    @(negedge clk_i);
    chk_all(tag);
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 0; rd_en_i = 0; clr_err_i = 0; data_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk_all("reset");

    for (int i = 0; i < 5; i++) cycle("idle", 0, 8'h00, 0, 0);

    for (int i = 0; i < 4; i++) cycle("fill", 1, 8'hA1 + 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) cycle("refill", 1, 8'hA1 + 8'(i), 0, 0);

    cycle("ovf_rd", 1, 8'hFF, 1, 0);
    for (int i = 0; i < 3; i++) cycle("ovf_drain", 0, 8'h00, 1, 0);

    cycle("unf", 0, 8'h00, 1, 0);
    cycle("clr", 0, 8'h00, 0, 1);
    cycle("clr_vs_unf", 0, 8'h00, 1, 1);
    cycle("clr_ovf", 0, 8'h00, 0, 1);
    cycle("unf_wr", 1, 8'h3C, 1, 0);
    cycle("rd_3c", 0, 8'h00, 1, 0);
    cycle("clr2", 0, 8'h00, 0, 1);

    cycle("pre0", 1, 8'h00, 0, 0);
    cycle("pre1", 1, 8'h01, 0, 0);
    for (int i = 0; i < 20; i++) cycle("stream", 1, 8'(i + 2), 1, 0);
    cycle("post0", 0, 8'h00, 1, 0);
    cycle("post1", 0, 8'h00, 1, 0);

    for (int i = 0; i < 3; i++) cycle("pre_rst", 1, 8'h70 + 8'(i), 0, 0);
    cycle("pre_rst_rd", 1, 8'h73, 1, 0);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_all("post_rst");
    cycle("wr5a", 1, 8'h5A, 0, 0);
    cycle("rd5a", 0, 8'h00, 1, 0);
    chk("readback_5a", 32'(data_o), 32'h5A);

    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
